// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO; frames go out LSB-first, back-to-back while data is queued.
// Latency: trmt into an idle, empty block -> start bit on TX two edges later; tx_done one cycle after the last stop bit.
// Backpressure: tx_full warns the writer; a trmt while full is dropped and latches tx_ovfl. Parity bit: UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_ovfl,
    output logic                 TX
);

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int BAUD_W     = $clog2(BAUD_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    // Elaboration-time guards on the parameter ranges the datapath relies on.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_fifo: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  sh_q, sh_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   done_q, done_d;
    logic                   ovfl_q, ovfl_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic [DATA_BITS-1:0]   head;
    logic [FRAME_BITS-1:0]  load_frame;
    logic [BIT_W-1:0]       bit_inc;

    assign tx_full  = (cnt_q == CNT_FULL);
    assign tx_empty = (cnt_q == '0);
    assign tx_busy  = (state_q == SHIFT);
    assign tx_done  = done_q;
    assign tx_ovfl  = ovfl_q;
    // The line is the LSB of the shift register, so TX is a plain flop output.
    assign TX       = sh_q[0];

    assign push    = trmt & ~tx_full;
    assign head    = mem_q[rd_ptr_q];
    assign bit_inc = bit_q + BIT_W'(1);

    // Frame image for the FIFO head: stop bits, optional parity, data, start bit (LSB goes out first).
    always_comb begin
`ifdef UART_TX_PARITY_EN
        load_frame = {{STOP_BITS{1'b1}}, ((PARITY_ODD != 0) ? ~^head : ^head), head, 1'b0};
`else
        load_frame = {{STOP_BITS{1'b1}}, head, 1'b0};
`endif
    end

    // Next-state logic: load from the FIFO when idle, or reload on the last baud tick for a gapless follow-on frame.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    pop     = 1'b1;
                    sh_d    = load_frame;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    sh_d   = {1'b1, sh_q[FRAME_BITS-1:1]};
                    bit_d  = bit_inc;
                    if (bit_inc == BIT_LAST) begin
                        done_d = 1'b1;
                        if (!tx_empty) begin
                            pop   = 1'b1;
                            sh_d  = load_frame;
                            bit_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a full FIFO refuses the write even if a pop frees a slot this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovfl_d   = ovfl_q | (trmt & tx_full);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset abandons any frame in flight and discards queued data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_q     <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            done_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
            ovfl_q   <= ovfl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor of the team's fixed 8N1 transmitter. Adds configurable data width, baud divisor, stop-bit count and a small input FIFO, so the command/response path can queue several bytes and send them back-to-back with no idle gap. An optional parity bit is compiled in by macro. Sits between the command processor and the board TX pin.

Parameters:
DATA_BITS, 8, bits per character; legal range 5..9
BAUD_DIV, 2604, clocks per bit period; must be >= 2
STOP_BITS, 1, stop bits per frame; 1 or 2
FIFO_DEPTH, 4, entries in the input FIFO; power of 2, >= 2
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
trmt  in  1  write strobe; pushes tx_data into the FIFO
tx_data  in  DATA_BITS  character to send
tx_full  out  1  FIFO holds FIFO_DEPTH entries
tx_empty  out  1  FIFO holds 0 entries
tx_busy  out  1  a frame is on the line
tx_done  out  1  one-cycle pulse when a frame's last stop bit completes
tx_ovfl  out  1  sticky flag: a write was dropped
TX  out  1  serial line, idles high

Behaviour:
- Reset: one clk, rst=1, synchronous. Afterwards TX=1, tx_busy=0, tx_done=0, tx_ovfl=0, tx_empty=1, tx_full=0. FIFO pointers, count, baud counter and bit counter all 0.
- Reset mid-frame: on the next edge TX=1 and the frame is abandoned. Queued data is discarded. No tx_done pulse.
- FIFO write: occurs when trmt=1 and tx_full=0 (registered flag).
  - trmt while tx_full=1 is dropped and sets tx_ovfl, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
- Frame format, LSB-first: start(0), DATA_BITS data bits, [parity], STOP_BITS stop bits(1).
  - F = 1 + DATA_BITS + P + STOP_BITS, where P = 1 if parity is compiled in, else 0.
  - Each bit lasts exactly BAUD_DIV clocks.
- FSM states: IDLE and SHIFT.
  - IDLE and FIFO not empty: pop the head into a shift register preloaded as {stop bits, [parity], data, 0}. Clear both counters. Go to SHIFT. TX=0 from the next cycle.
  - SHIFT: the baud counter counts 0..BAUD_DIV-1. At the terminal count, shift right filling with 1, increment the bit counter, and clear the baud counter.
  - When the bit counter reaches F at the terminal count: pulse tx_done.
    - If the FIFO is not empty, pop and reload in that same cycle and stay in SHIFT. The next start bit follows with zero gap.
    - Otherwise go to IDLE with TX=1.
- Latency: trmt at edge N into an empty FIFO with FSM IDLE gives:
  - FIFO non-empty after edge N.
  - Pop at edge N+1; tx_busy=1 and TX=0 from edge N+1.
  - tx_done high in the cycle after edge N+1+F*BAUD_DIV.
- tx_busy = (state==SHIFT). tx_empty and tx_full derive from the registered count.
- TX is a direct flop output with no combinational path from inputs.
- Counter widths: baud counter is clog2(BAUD_DIV) bits; bit counter is clog2(F+1) bits. No wrap-around is possible within legal parameters.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: one parity bit is inserted after the data bits. Its value is ^data for even parity (PARITY_ODD=0) or ~^data for odd parity (PARITY_ODD=1). F grows by 1.
- Undefined: no parity bit is sent, PARITY_ODD is ignored, and no parity logic is synthesised.

Test Plan:
1. Defaults except BAUD_DIV=16, no parity. Write 0xA5 once. TX emits 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. One tx_done pulse 160 clocks after TX falls. tx_busy drops with it.
2. Write 0x11, 0x22, 0x33 on consecutive cycles. Three contiguous frames with no idle clock between stop and start. tx_done pulses 160 clocks apart. tx_empty=1 after the third pop.
3. FIFO_DEPTH=4, FSM idle: 6 writes on consecutive cycles. 5 accepted (one popped at cycle 1), sixth dropped, tx_ovfl=1 and stays 1. Exactly 5 frames sent.
4. UART_TX_PARITY_EN defined, PARITY_ODD=0, write 0x07. Parity bit = 1. Frame is 11 bits (176 clocks at BAUD_DIV=16). With PARITY_ODD=1 the parity bit = 0.
5. DATA_BITS=7, STOP_BITS=2, write 0x55. Frame is 0,1,0,1,0,1,0,1,1,1 (10 bits). tx_done 160 clocks after start.
6. Assert rst for one cycle during data bit 3 with 2 bytes queued. TX=1 next cycle, tx_busy=0, tx_empty=1, no tx_done pulse, no further frames.
